// File: rtl/instruction_fetch_if.sv
// Signal bundle between the IF stage and its surroundings (hazard unit, EX redirect,
// instruction memory, IF/ID consumer). The master side is the IF stage itself.
interface instruction_fetch_if;
  logic        i_stall;
  logic        i_redirect_valid;
  logic [31:0] i_redirect_pc;
  logic [31:0] o_imem_addr;
  logic [31:0] i_imem_instr;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_instr;
  logic        o_if_id_valid;
  logic [31:0] o_fetch_count;
  logic        o_fault_range;
  logic        o_fault_misalign;

  modport master (
    input  i_stall, i_redirect_valid, i_redirect_pc, i_imem_instr,
    output o_imem_addr, o_if_id_pc, o_if_id_instr, o_if_id_valid,
           o_fetch_count, o_fault_range, o_fault_misalign
  );

  modport slave (
    output i_stall, i_redirect_valid, i_redirect_pc, i_imem_instr,
    input  o_imem_addr, o_if_id_pc, o_if_id_instr, o_if_id_valid,
           o_fetch_count, o_fault_range, o_fault_misalign
  );
endinterface

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, reads a zero-latency instruction memory and fills the IF/ID latch,
// honouring stalls and EX redirects; out-of-range and misaligned fetches become bubbles.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input logic               i_clk,
  input logic               i_rst,
  instruction_fetch_if.master bus
);

  localparam logic [29:0] WORD_LIMIT = 30'(IMEM_WORDS);

  // Handshake: i_redirect_valid is a one-cycle command with no ready; it is always
  // accepted at the edge where it is high and takes precedence over i_stall.
  logic [31:0] pc;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [31:0] fetch_count;
  logic        fault_range;
  logic        fault_misalign;
  logic        pc_in_range;

  assign pc_in_range = (pc[31:2] < WORD_LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc             <= RESET_PC;
      if_id_pc       <= 32'h0;
      if_id_instr    <= NOP_INSTR;
      if_id_valid    <= 1'b0;
      fetch_count    <= 32'h0;
      fault_range    <= 1'b0;
      fault_misalign <= 1'b0;
    end else if (bus.i_redirect_valid) begin
      // The fetch in flight belongs to the wrong path, so it is replaced by a bubble.
      pc          <= {bus.i_redirect_pc[31:2], 2'b00};
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if (bus.i_redirect_pc[1:0] != 2'b00) fault_misalign <= 1'b1;
    end else if (bus.i_stall) begin
      pc          <= pc;
      if_id_pc    <= if_id_pc;
      if_id_instr <= if_id_instr;
      if_id_valid <= if_id_valid;
    end else if (!pc_in_range) begin
      // PC parks here until a redirect moves it back into the memory.
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      fault_range <= 1'b1;
    end else begin
      pc          <= pc + 32'd4;
      if_id_pc    <= pc;
      if_id_instr <= bus.i_imem_instr;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign bus.o_imem_addr      = pc;
  assign bus.o_if_id_pc       = if_id_pc;
  assign bus.o_if_id_instr    = if_id_instr;
  assign bus.o_if_id_valid    = if_id_valid;
  assign bus.o_fetch_count    = fetch_count;
  assign bus.o_fault_range    = fault_range;
  assign bus.o_fault_misalign = fault_misalign;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of per-cycle inputs and hand-computed
// outputs, followed by short sequences for reset-during-request and misaligned in-range redirects.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_WORDS(32),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus.master)
  );

  // Memory model: 64 words so the out-of-range word 32 still returns defined data.
  logic [31:0] mem [64];
  assign bus.i_imem_instr = mem[bus.o_imem_addr[7:2]];

  function automatic logic [31:0] m(input int idx);
    return 32'hC0DE_0000 + 32'(idx);
  endfunction

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] count;
    logic        frange;
    logic        fmis;
  } obs_t;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    obs_t        exp;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic obs_t mk(input logic [31:0] addr, input logic [31:0] pc,
                              input logic [31:0] instr, input logic valid,
                              input logic [31:0] count, input logic frange,
                              input logic fmis);
    obs_t o;
    o.addr = addr; o.pc = pc; o.instr = instr; o.valid = valid;
    o.count = count; o.frange = frange; o.fmis = fmis;
    return o;
  endfunction

  task automatic add_vec(input logic stall, input logic rv, input logic [31:0] rpc,
                         input obs_t exp);
    vec_t v;
    v.stall = stall; v.rv = rv; v.rpc = rpc; v.exp = exp;
    vq.push_back(v);
  endtask

  function automatic obs_t sample();
    return mk(bus.o_imem_addr, bus.o_if_id_pc, bus.o_if_id_instr, bus.o_if_id_valid,
              bus.o_fetch_count, bus.o_fault_range, bus.o_fault_misalign);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got addr=%h pc=%h instr=%h valid=%b count=%0d frange=%b fmis=%b, want addr=%h pc=%h instr=%h valid=%b count=%0d frange=%b fmis=%b",
               name, act.addr, act.pc, act.instr, act.valid, act.count, act.frange, act.fmis,
               exp.addr, exp.pc, exp.instr, exp.valid, exp.count, exp.frange, exp.fmis);
    end
  endtask

  task automatic drive_edge(input logic rst, input logic stall, input logic rv,
                            input logic [31:0] rpc);
    @(negedge i_clk);
    i_rst = rst;
    bus.i_stall = stall;
    bus.i_redirect_valid = rv;
    bus.i_redirect_pc = rpc;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = m(i);
    bus.i_stall = 1'b0;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc = 32'h0;

    // Reset held for two edges
    drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
    drive_edge(1'b1, 1'b0, 1'b0, 32'h0);
    check("reset", mk(32'h0, 32'h0, NOP, 1'b0, 0, 1'b0, 1'b0));

    // stall, redirect_valid, redirect_pc -> addr, if_id pc, instr, valid, count, frange, fmis
    add_vec(0, 0, 32'h0,  mk(32'h04, 32'h00, m(0),  1, 1, 0, 0));
    add_vec(0, 0, 32'h0,  mk(32'h08, 32'h04, m(1),  1, 2, 0, 0));
    add_vec(1, 0, 32'h0,  mk(32'h08, 32'h04, m(1),  1, 2, 0, 0));
    add_vec(1, 0, 32'h0,  mk(32'h08, 32'h04, m(1),  1, 2, 0, 0));
    add_vec(0, 0, 32'h0,  mk(32'h0C, 32'h08, m(2),  1, 3, 0, 0));
    add_vec(1, 1, 32'h40, mk(32'h40, 32'h00, NOP,   0, 3, 0, 0));
    add_vec(0, 0, 32'h0,  mk(32'h44, 32'h40, m(16), 1, 4, 0, 0));
    add_vec(0, 1, 32'h82, mk(32'h80, 32'h00, NOP,   0, 4, 0, 1));
    add_vec(0, 0, 32'h0,  mk(32'h80, 32'h00, NOP,   0, 4, 1, 1));
    add_vec(0, 0, 32'h0,  mk(32'h80, 32'h00, NOP,   0, 4, 1, 1));
    add_vec(1, 0, 32'h0,  mk(32'h80, 32'h00, NOP,   0, 4, 1, 1));
    add_vec(0, 1, 32'h00, mk(32'h00, 32'h00, NOP,   0, 4, 1, 1));
    add_vec(0, 0, 32'h0,  mk(32'h04, 32'h00, m(0),  1, 5, 1, 1));
    add_vec(0, 0, 32'h0,  mk(32'h08, 32'h04, m(1),  1, 6, 1, 1));
    add_vec(0, 1, 32'h10, mk(32'h10, 32'h00, NOP,   0, 6, 1, 1));
    add_vec(1, 0, 32'h0,  mk(32'h10, 32'h00, NOP,   0, 6, 1, 1));
    add_vec(0, 0, 32'h0,  mk(32'h14, 32'h10, m(4),  1, 7, 1, 1));

    for (int i = 0; i < vq.size(); i++) begin
      drive_edge(1'b0, vq[i].stall, vq[i].rv, vq[i].rpc);
      check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Reset arriving together with stall and redirect discards both and clears faults
    drive_edge(1'b1, 1'b1, 1'b1, 32'h40);
    check("rst_over_redirect", mk(32'h0, 32'h0, NOP, 1'b0, 0, 1'b0, 1'b0));
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    check("first_after_rst", mk(32'h04, 32'h00, m(0), 1'b1, 1, 1'b0, 1'b0));

    // Misaligned but in-range target: word-aligned PC, misalign flag only
    drive_edge(1'b0, 1'b0, 1'b1, 32'h0000_0026);
    check("misalign_redirect", mk(32'h24, 32'h00, NOP, 1'b0, 1, 1'b0, 1'b1));
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    check("misalign_resume", mk(32'h28, 32'h24, m(9), 1'b1, 2, 1'b0, 1'b1));

    // Last in-range word, then falling off the end of memory
    drive_edge(1'b0, 1'b0, 1'b1, 32'h7C);
    check("redirect_last", mk(32'h7C, 32'h00, NOP, 1'b0, 2, 1'b0, 1'b1));
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    check("fetch_last", mk(32'h80, 32'h7C, m(31), 1'b1, 3, 1'b0, 1'b1));
    drive_edge(1'b0, 1'b0, 1'b0, 32'h0);
    check("past_end", mk(32'h80, 32'h00, NOP, 1'b0, 3, 1'b1, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
